// File: rtl/aibio_cdr_pkg.sv
// Shared types for the RX CDR phase controller: FSM state and PI step direction.
package aibio_cdr_pkg;

  typedef enum logic [1:0] {IDLE, TRACK, STEP, SETTLE} cdr_state_e;
  typedef enum logic {DIR_UP, DIR_DN} cdr_dir_e;

endpackage

// File: rtl/aibio_cdr_sync.sv
// Two-flop synchronizer for a single asynchronous bit, async active-high reset to 0.
module aibio_cdr_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic sync_p0;

  // Stage 0 samples the async input, stage 1 is the metastability-filtered output
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_p0 <= 1'b0;
      o_q     <= 1'b0;
    end else begin
      sync_p0 <= i_d;
      o_q     <= sync_p0;
    end
  end

endmodule

// File: rtl/aibio_cdr_phase_ctrl.sv
// RX CDR loop filter and PI-code controller: early/late integrator, +/-1 code steps, settle window.
// Optional lock detector built only when AIBIO_CDR_LOCK_DET_EN is defined.
module aibio_cdr_phase_ctrl #(
  parameter int CODE_W   = 7,
  parameter int ACC_W    = 5,
  parameter int TH       = 8,
  parameter int SETTLE   = 4,
  parameter int CODE_RST = 0,
  parameter int LOCK_ALT = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cdr_en,
  input  logic              i_cdr_phdet,
  input  logic              i_code_load,
  input  logic [CODE_W-1:0] i_pi_code_init,
  output logic [CODE_W-1:0] o_pi_code,
  output logic              o_pi_up,
  output logic              o_pi_dn,
  output logic              o_cdr_lock
);

  import aibio_cdr_pkg::*;

  // The parameter SETTLE shadows the state name, so the state is always package-qualified.
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] TH_POS  = ACC_W'(TH);
  localparam logic signed [ACC_W-1:0] TH_NEG  = -TH_POS;

  function automatic logic [CODE_W-1:0] code_step(input logic [CODE_W-1:0] code,
                                                  input cdr_dir_e dir);
    // Natural CODE_W-bit wrap gives the modular PI code ring
    if (dir == DIR_UP) code_step = code + 1'b1;
    else               code_step = code - 1'b1;
  endfunction

  cdr_state_e               state_q, state_d;
  cdr_dir_e                 dir_q, dir_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_nxt;
  logic        [CNT_W-1:0]  cnt_q, cnt_d;
  logic        [CODE_W-1:0] code_q;
  logic                     up_q, dn_q;
  logic                     phd_s;
  logic                     step_fire;

  aibio_cdr_sync u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_cdr_phdet),
    .o_q     (phd_s)
  );

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    step_fire = 1'b0;
    acc_nxt   = phd_s ? (acc_q + ACC_ONE) : (acc_q - ACC_ONE);
    if (!i_cdr_en) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          acc_d   = '0;
          state_d = TRACK;
        end
        TRACK: begin
          if (acc_nxt == TH_POS) begin
            state_d = STEP;
            dir_d   = DIR_UP;
            acc_d   = '0;
          end else if (acc_nxt == TH_NEG) begin
            state_d = STEP;
            dir_d   = DIR_DN;
            acc_d   = '0;
          end else begin
            acc_d = acc_nxt;
          end
        end
        STEP: begin
          step_fire = 1'b1;
          cnt_d     = CNT_W'(SETTLE - 1);
          state_d   = aibio_cdr_pkg::SETTLE;
        end
        aibio_cdr_pkg::SETTLE: begin
          acc_d = '0;
          if (cnt_q == '0) state_d = TRACK;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      dir_q   <= DIR_UP;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Code register and step pulses: the pulse is registered with the code so they coincide
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      code_q <= CODE_W'(CODE_RST);
      up_q   <= 1'b0;
      dn_q   <= 1'b0;
    end else begin
      up_q <= 1'b0;
      dn_q <= 1'b0;
      if (state_q == IDLE && i_code_load) begin
        code_q <= i_pi_code_init;
      end else if (step_fire) begin
        code_q <= code_step(code_q, dir_q);
        up_q   <= (dir_q == DIR_UP);
        dn_q   <= (dir_q == DIR_DN);
      end
    end
  end

  assign o_pi_code = code_q;
  assign o_pi_up   = up_q;
  assign o_pi_dn   = dn_q;

`ifdef AIBIO_CDR_LOCK_DET_EN
  localparam int LK_W = $clog2(LOCK_ALT + 1);

  logic [LK_W-1:0] lock_cnt_q;
  logic            have_prev_q;
  cdr_dir_e        prev_dir_q;
  logic            lock_q;

  // The first step after IDLE has no predecessor and counts as an alternation,
  // so LOCK_ALT alternating steps (up,dn,up,dn at the default) declare lock.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      lock_cnt_q  <= '0;
      have_prev_q <= 1'b0;
      prev_dir_q  <= DIR_UP;
      lock_q      <= 1'b0;
    end else if (!i_cdr_en) begin
      lock_cnt_q  <= '0;
      have_prev_q <= 1'b0;
      lock_q      <= 1'b0;
    end else if (step_fire) begin
      have_prev_q <= 1'b1;
      prev_dir_q  <= dir_q;
      if (!have_prev_q || dir_q != prev_dir_q) begin
        if (lock_cnt_q != LK_W'(LOCK_ALT)) lock_cnt_q <= lock_cnt_q + 1'b1;
        if (lock_cnt_q >= LK_W'(LOCK_ALT - 1)) lock_q <= 1'b1;
      end else begin
        lock_cnt_q <= '0;
        lock_q     <= 1'b0;
      end
    end
  end

  assign o_cdr_lock = lock_q;
`else
  assign o_cdr_lock = 1'b0;
`endif

endmodule

// File: tb/tb_aibio_cdr_phase_ctrl.sv
// Self-checking bench for aibio_cdr_phase_ctrl: directed vector table plus multi-cycle sequences.
module tb_aibio_cdr_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, phd, load;
  logic [6:0] init, code;
  logic       up, dn, lock;

  always #5 clk = ~clk;

  aibio_cdr_phase_ctrl dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_cdr_en       (en),
    .i_cdr_phdet    (phd),
    .i_code_load    (load),
    .i_pi_code_init (init),
    .o_pi_code      (code),
    .o_pi_up        (up),
    .o_pi_dn        (dn),
    .o_cdr_lock     (lock)
  );

`ifdef AIBIO_CDR_LOCK_DET_EN
  localparam logic EXP_LOCK = 1'b1;
`else
  localparam logic EXP_LOCK = 1'b0;
`endif

  typedef struct {
    logic       en;
    logic       phd;
    logic       load;
    logic [6:0] init;
    logic [6:0] exp_code;
    logic       exp_up;
    logic       exp_dn;
    string      name;
  } vec_t;

  vec_t vecs[8];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs n cycles and returns how many step pulses were seen
  task automatic run_quiet(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (up || dn) pulses++;
    end
  endtask

  // Bounded wait for the next step pulse
  task automatic wait_pulse(output logic got_up, output logic got_dn);
    int  cyc;
    logic seen;
    cyc = 0; seen = 1'b0; got_up = 1'b0; got_dn = 1'b0;
    while (!seen && cyc < 40) begin
      tick();
      cyc++;
      if (up || dn) begin
        seen   = 1'b1;
        got_up = up;
        got_dn = dn;
      end
    end
    chk("pulse_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic prime_and_enable(input logic p);
    en = 1'b0;
    tick();
    phd = p;
    repeat (3) tick();
    en = 1'b1;
  endtask

  initial begin
    int   q;
    logic gu, gd;
    logic [6:0] c0;
    logic exp_dirs[6];
    logic exp_lk[6];

    vecs[0] = '{1'b0, 1'b0, 1'b1, 7'd5,   7'd5,   1'b0, 1'b0, "load_idle_5"};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 7'd9,   7'd5,   1'b0, 1'b0, "no_load_hold"};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 7'd100, 7'd100, 1'b0, 1'b0, "load_idle_100"};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 7'd33,  7'd33,  1'b0, 1'b0, "load_idle_en"};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 7'd7,   7'd33,  1'b0, 1'b0, "load_ignored_track"};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 7'd7,   7'd33,  1'b0, 1'b0, "load_ignored_track2"};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 7'd0,   7'd33,  1'b0, 1'b0, "drop_en_hold"};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 7'd0,   7'd0,   1'b0, 1'b0, "load_idle_0"};

    rst = 1'b1; en = 1'b0; phd = 1'b0; load = 1'b0; init = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("rst_code", {25'd0, code}, 32'd0);
    chk("rst_up",   {31'd0, up},   32'd0);
    chk("rst_dn",   {31'd0, dn},   32'd0);
    chk("rst_lock", {31'd0, lock}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      en = vecs[i].en; phd = vecs[i].phd; load = vecs[i].load; init = vecs[i].init;
      tick();
      chk({vecs[i].name, "_code"}, {25'd0, code}, {25'd0, vecs[i].exp_code});
      chk({vecs[i].name, "_pulse"}, {30'd0, up, dn}, {30'd0, vecs[i].exp_up, vecs[i].exp_dn});
    end
    load = 1'b0;

    // Constant late: first pulse 10 cycles after enable (1 to TRACK + 8 accumulate + 1 STEP)
    prime_and_enable(1'b1);
    run_quiet(9, q);
    chk("first_quiet", q, 0);
    tick();
    chk("first_step", {23'd0, up, dn, code}, {23'd0, 2'b10, 7'd1});
    for (int k = 2; k <= 4; k++) begin
      run_quiet(12, q);
      chk("period_quiet", q, 0);
      tick();
      chk("period_step", {23'd0, up, dn, code}, {23'd0, 2'b10, 7'(k)});
    end
    chk("same_dir_no_lock", {31'd0, lock}, 32'd0);

    // Asynchronous reset mid-run while a pulse is high
    rst = 1'b1;
    #1;
    chk("async_rst", {22'd0, up, dn, lock, code}, 32'd0);
    tick();
    rst = 1'b0; en = 1'b0;
    tick();

    // Wrap both ways
    load = 1'b1; init = 7'd127;
    tick();
    load = 1'b0;
    chk("load_127", {25'd0, code}, 32'd127);
    prime_and_enable(1'b1);
    wait_pulse(gu, gd);
    chk("wrap_up", {23'd0, gu, gd, code}, {23'd0, 2'b10, 7'd0});
    en = 1'b0;
    tick();
    load = 1'b1; init = 7'd0;
    tick();
    load = 1'b0;
    prime_and_enable(1'b0);
    wait_pulse(gu, gd);
    chk("wrap_dn", {23'd0, gu, gd, code}, {23'd0, 2'b01, 7'd127});

    // Drop enable while in STEP: no pulse, code held, then clean restart
    prime_and_enable(1'b1);
    run_quiet(9, q);
    chk("pre_step_quiet", q, 0);
    en = 1'b0;
    tick();
    chk("step_drop", {23'd0, up, dn, code}, {23'd0, 2'b00, 7'd127});
    run_quiet(15, q);
    chk("step_drop_quiet", q, 0);
    en = 1'b1;
    run_quiet(9, q);
    chk("step_resume_quiet", q, 0);
    tick();
    chk("step_resume", {23'd0, up, dn, code}, {23'd0, 2'b10, 7'd0});

    // Drop enable while in SETTLE
    en = 1'b0;
    tick();
    chk("settle_drop", {23'd0, up, dn, code}, {23'd0, 2'b00, 7'd0});
    run_quiet(15, q);
    chk("settle_drop_quiet", q, 0);
    en = 1'b1;
    run_quiet(9, q);
    chk("settle_resume_quiet", q, 0);
    tick();
    chk("settle_resume", {23'd0, up, dn, code}, {23'd0, 2'b10, 7'd1});

    // Alternating phdet every cycle: integrator never reaches threshold
    en = 1'b0;
    tick();
    c0 = code;
    for (int i = 0; i < 3; i++) begin
      phd = ~phd;
      tick();
    end
    en = 1'b1;
    q = 0;
    for (int i = 0; i < 200; i++) begin
      phd = ~phd;
      tick();
      if (up || dn) q++;
    end
    chk("dither_no_pulse", q, 0);
    chk("dither_code", {25'd0, code}, {25'd0, c0});

    // Lock: up,dn,up,dn locks; a further up still alternates; up,up clears
    exp_dirs = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_lk   = '{1'b0, 1'b0, 1'b0, EXP_LOCK, EXP_LOCK, 1'b0};
    prime_and_enable(1'b1);
    for (int i = 0; i < 6; i++) begin
      phd = exp_dirs[i];
      wait_pulse(gu, gd);
      chk("lock_step_dir", {30'd0, gu, gd}, {30'd0, exp_dirs[i], ~exp_dirs[i]});
      chk("lock_flag", {31'd0, lock}, {31'd0, exp_lk[i]});
    end
    en = 1'b0;
    tick();
    chk("lock_idle_clear", {31'd0, lock}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
